// File: rtl/cla_pipe_adder.sv
// Two-stage pipelined carry-lookahead adder/subtractor.
// Stage 1 forms group generate/propagate and carry-select sums; stage 2 resolves group carries.
module cla_pipe_adder #(
    parameter int WIDTH = 16,
    parameter int GROUP = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             sub,
    output logic             out_valid,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf,
    output logic             zero
);

    localparam int NG  = WIDTH / GROUP;
    localparam int MSB = WIDTH - 1;

    generate
        if (GROUP < 1 || WIDTH < GROUP || (WIDTH % GROUP) != 0) begin : g_bad_params
            $error("cla_pipe_adder: WIDTH must be a non-zero multiple of GROUP");
        end
    endgenerate

    // ---------------- stage 1: per-group lookahead terms ----------------
    logic [WIDTH-1:0] b_eff;
    logic [WIDTH-1:0] p;
    logic [WIDTH-1:0] g;
    logic [NG-1:0]    grp_g_d;
    logic [NG-1:0]    grp_p_d;
    logic [WIDTH-1:0] sum0_d;
    logic [WIDTH-1:0] sum1_d;

    assign b_eff = b ^ {WIDTH{sub}};
    assign p     = a ^ b_eff;
    assign g     = a & b_eff;

    always_comb begin
        // NOTE: every combinational output gets a default first so no path can infer a latch.
        grp_g_d = '0;
        grp_p_d = '0;
        sum0_d  = '0;
        sum1_d  = '0;
        for (int i = 0; i < NG; i++) begin
            grp_p_d[i] = &p[i*GROUP +: GROUP];
            for (int j = 0; j < GROUP; j++) begin
                grp_g_d[i] = g[i*GROUP+j] | (p[i*GROUP+j] & grp_g_d[i]);
            end
            sum0_d[i*GROUP +: GROUP] = a[i*GROUP +: GROUP] + b_eff[i*GROUP +: GROUP];
            sum1_d[i*GROUP +: GROUP] = a[i*GROUP +: GROUP] + b_eff[i*GROUP +: GROUP] + GROUP'(1);
        end
    end

    logic             v1;
    logic [NG-1:0]    grp_g_q;
    logic [NG-1:0]    grp_p_q;
    logic [WIDTH-1:0] sum0_q;
    logic [WIDTH-1:0] sum1_q;
    logic             a_msb_q;
    logic             b_msb_q;
    logic             cin_q;

    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignment so every register samples pre-edge values.
        if (rst) begin
            v1      <= 1'b0;
            grp_g_q <= '0;
            grp_p_q <= '0;
            sum0_q  <= '0;
            sum1_q  <= '0;
            a_msb_q <= 1'b0;
            b_msb_q <= 1'b0;
            cin_q   <= 1'b0;
        end else begin
            v1 <= in_valid;
            if (in_valid) begin
                grp_g_q <= grp_g_d;
                grp_p_q <= grp_p_d;
                sum0_q  <= sum0_d;
                sum1_q  <= sum1_d;
                a_msb_q <= a[MSB];
                b_msb_q <= b_eff[MSB];
                cin_q   <= cin;
            end
        end
    end

    // ---------------- stage 2: second-level lookahead and select ----------------
    logic [NG:0]      c;
    logic             prod;
    logic             carry_terms;
    logic [WIDTH-1:0] sum_sel;

    // Each group carry is a flat sum of products over the group G/P terms and cin.
    always_comb begin
        c           = '0;
        prod        = 1'b0;
        carry_terms = 1'b0;
        c[0]        = cin_q;
        for (int i = 0; i < NG; i++) begin
            carry_terms = 1'b0;
            for (int j = 0; j <= i; j++) begin
                prod = grp_g_q[j];
                for (int k = j + 1; k <= i; k++) begin
                    prod = prod & grp_p_q[k];
                end
                carry_terms = carry_terms | prod;
            end
            prod = cin_q;
            for (int k = 0; k <= i; k++) begin
                prod = prod & grp_p_q[k];
            end
            c[i+1] = carry_terms | prod;
        end
    end

    always_comb begin
        sum_sel = '0;
        for (int i = 0; i < NG; i++) begin
            sum_sel[i*GROUP +: GROUP] = c[i] ? sum1_q[i*GROUP +: GROUP] : sum0_q[i*GROUP +: GROUP];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid <= 1'b0;
            sum       <= '0;
            cout      <= 1'b0;
            ovf       <= 1'b0;
            zero      <= 1'b0;
        end else begin
            out_valid <= v1;
            if (v1) begin
                sum  <= sum_sel;
                cout <= c[NG];
                ovf  <= (a_msb_q == b_msb_q) && (sum_sel[MSB] != a_msb_q);
                zero <= (sum_sel == '0);
            end
        end
    end

endmodule

// File: tb/tb_cla_pipe_adder.sv
// Directed and randomised bench for cla_pipe_adder at 8/4, 16/4, 32/4 and 32/8.
// All four instances see the same (truncated) stimulus; directed tests check the 16/4 instance.
module tb_cla_pipe_adder;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic [31:0] a_drv;
    logic [31:0] b_drv;
    logic        cin;
    logic        sub;

    logic [7:0]  s8;
    logic [15:0] s16;
    logic [31:0] s32a;
    logic [31:0] s32b;
    logic        ovld [4];
    logic        oc   [4];
    logic        oo   [4];
    logic        oz   [4];
    logic [31:0] os   [4];

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    cla_pipe_adder #(.WIDTH(8), .GROUP(4)) dut_w8 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .a(a_drv[7:0]), .b(b_drv[7:0]),
        .cin(cin), .sub(sub), .out_valid(ovld[0]), .sum(s8), .cout(oc[0]), .ovf(oo[0]), .zero(oz[0]));

    cla_pipe_adder #(.WIDTH(16), .GROUP(4)) dut_w16 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .a(a_drv[15:0]), .b(b_drv[15:0]),
        .cin(cin), .sub(sub), .out_valid(ovld[1]), .sum(s16), .cout(oc[1]), .ovf(oo[1]), .zero(oz[1]));

    cla_pipe_adder #(.WIDTH(32), .GROUP(4)) dut_w32g4 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .a(a_drv), .b(b_drv),
        .cin(cin), .sub(sub), .out_valid(ovld[2]), .sum(s32a), .cout(oc[2]), .ovf(oo[2]), .zero(oz[2]));

    cla_pipe_adder #(.WIDTH(32), .GROUP(8)) dut_w32g8 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .a(a_drv), .b(b_drv),
        .cin(cin), .sub(sub), .out_valid(ovld[3]), .sum(s32b), .cout(oc[3]), .ovf(oo[3]), .zero(oz[3]));

    assign os[0] = {24'd0, s8};
    assign os[1] = {16'd0, s16};
    assign os[2] = s32a;
    assign os[3] = s32b;

    // Behavioural reference: {zero, ovf, cout, sum} of a + b_eff + cin at width w.
    function automatic logic [34:0] model(input int w, input logic [31:0] av, input logic [31:0] bv,
                                          input logic ci, input logic sb);
        logic [32:0] mask;
        logic [32:0] full;
        logic [31:0] aa;
        logic [31:0] be;
        logic [31:0] s;
        logic        co;
        logic        ov;
        mask = (33'd1 << w) - 33'd1;
        aa   = av & mask[31:0];
        be   = (bv ^ {32{sb}}) & mask[31:0];
        full = {1'b0, aa} + {1'b0, be} + {32'd0, ci};
        s    = full[31:0] & mask[31:0];
        co   = full[w];
        ov   = (aa[w-1] == be[w-1]) && (s[w-1] != aa[w-1]);
        return {(s == 32'd0), ov, co, s};
    endfunction

    // Drive one operation, then stop at the sample point two edges later.
    task automatic run_op(input logic [31:0] av, input logic [31:0] bv, input logic ci, input logic sb);
        @(negedge clk);
        a_drv = av; b_drv = bv; cin = ci; sub = sb; in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst = 1'b1; in_valid = 1'b1; a_drv = 32'h1234; b_drv = 32'h1234; cin = 1'b0; sub = 1'b0;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            n_vec++;
            if ({ovld[1], oc[1], oo[1], oz[1], s16} !== 20'h0) begin
                n_err++;
                $display("FAIL reset_cycle%0d: got v/c/o/z/sum=%b%b%b%b %h, want 0000 0000",
                         k, ovld[1], oc[1], oo[1], oz[1], s16);
            end
            if (k == 2) begin
                rst = 1'b0; in_valid = 1'b0;
            end
        end
    endtask

    task automatic test_carry_chain();
        logic [19:0] want;
        want = {1'b1, 1'b1, 1'b0, 1'b1, 16'h0000};
        run_op(32'hFFFF, 32'h0001, 1'b0, 1'b0);
        n_vec++;
        if ({ovld[1], oc[1], oo[1], oz[1], s16} !== want) begin
            n_err++;
            $display("FAIL carry_chain_b1: got %h, want %h", {ovld[1], oc[1], oo[1], oz[1], s16}, want);
        end
        run_op(32'hFFFF, 32'h0000, 1'b1, 1'b0);
        n_vec++;
        if ({ovld[1], oc[1], oo[1], oz[1], s16} !== want) begin
            n_err++;
            $display("FAIL carry_chain_cin: got %h, want %h", {ovld[1], oc[1], oo[1], oz[1], s16}, want);
        end
    endtask

    task automatic test_overflow_add();
        logic [19:0] want;
        want = {1'b1, 1'b0, 1'b1, 1'b0, 16'h8000};
        run_op(32'h7FFF, 32'h0001, 1'b0, 1'b0);
        n_vec++;
        if ({ovld[1], oc[1], oo[1], oz[1], s16} !== want) begin
            n_err++;
            $display("FAIL ovf_add: got %h, want %h", {ovld[1], oc[1], oo[1], oz[1], s16}, want);
        end
    endtask

    task automatic test_subtract();
        logic [19:0] want;
        want = {1'b1, 1'b0, 1'b0, 1'b0, 16'hFFFE};
        run_op(32'h0005, 32'h0007, 1'b1, 1'b1);
        n_vec++;
        if ({ovld[1], oc[1], oo[1], oz[1], s16} !== want) begin
            n_err++;
            $display("FAIL sub_borrow: got %h, want %h", {ovld[1], oc[1], oo[1], oz[1], s16}, want);
        end
        want = {1'b1, 1'b1, 1'b1, 1'b0, 16'h7FFF};
        run_op(32'h8000, 32'h0001, 1'b1, 1'b1);
        n_vec++;
        if ({ovld[1], oc[1], oo[1], oz[1], s16} !== want) begin
            n_err++;
            $display("FAIL sub_ovf: got %h, want %h", {ovld[1], oc[1], oo[1], oz[1], s16}, want);
        end
    endtask

    // Four back-to-back, two idle, one more; expected {cout, ovf, zero, sum} hand-computed.
    logic        st_v [9] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
    logic [15:0] st_a [9] = '{16'h1111, 16'h8000, 16'h1000, 16'hABCD, 16'h0, 16'h0, 16'h4000, 16'h0, 16'h0};
    logic [15:0] st_b [9] = '{16'h2222, 16'h8000, 16'h0001, 16'h1234, 16'h0, 16'h0, 16'h4000, 16'h0, 16'h0};
    logic        st_c [9] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    logic        st_s [9] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    logic [18:0] st_x [9] = '{{3'b000, 16'h3333}, {3'b111, 16'h0000}, {3'b100, 16'h0FFF},
                             {3'b000, 16'hBE02}, 19'h0, 19'h0, {3'b010, 16'h8000}, 19'h0, 19'h0};

    task automatic test_back_to_back();
        int held;
        held = 0;
        for (int k = 0; k < 9; k++) begin
            @(negedge clk);
            if (k >= 2) begin
                if (st_v[k-2]) held = k - 2;
                n_vec++;
                if (ovld[1] !== st_v[k-2] || {oc[1], oo[1], oz[1], s16} !== st_x[held]) begin
                    n_err++;
                    $display("FAIL stream_step%0d: got v=%b data=%h, want v=%b data=%h",
                             k, ovld[1], {oc[1], oo[1], oz[1], s16}, st_v[k-2], st_x[held]);
                end
            end
            in_valid = st_v[k];
            a_drv = {16'd0, st_a[k]}; b_drv = {16'd0, st_b[k]}; cin = st_c[k]; sub = st_s[k];
        end
        in_valid = 1'b0;
    endtask

    task automatic test_reset_mid_flight();
        @(negedge clk);
        a_drv = 32'h0123; b_drv = 32'h0456; cin = 1'b0; sub = 1'b0; in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0; rst = 1'b1;
        @(negedge clk);
        n_vec++;
        if (ovld[1] !== 1'b0 || s16 !== 16'h0) begin
            n_err++;
            $display("FAIL midreset_flush: got v=%b sum=%h, want v=0 sum=0000", ovld[1], s16);
        end
        rst = 1'b0; a_drv = 32'h0003; b_drv = 32'h0004; in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        n_vec++;
        if (ovld[1] !== 1'b0) begin
            n_err++;
            $display("FAIL midreset_no_ghost: got v=%b, want v=0", ovld[1]);
        end
        @(negedge clk);
        n_vec++;
        if (ovld[1] !== 1'b1 || s16 !== 16'h0007) begin
            n_err++;
            $display("FAIL post_reset_accept: got v=%b sum=%h, want v=1 sum=0007", ovld[1], s16);
        end
    endtask

    localparam int NSW = 1002;
    logic [31:0] sw_a [NSW];
    logic [31:0] sw_b [NSW];
    logic        sw_c [NSW];
    logic        sw_s [NSW];
    int          wd   [4] = '{8, 16, 32, 32};

    task automatic test_param_sweep();
        logic [34:0] want;
        sw_a[0] = 32'hFFFF_FFFF; sw_b[0] = 32'h0; sw_c[0] = 1'b1; sw_s[0] = 1'b0;
        sw_a[1] = 32'hFFFF_FFFF; sw_b[1] = 32'hFFFF_FFFF; sw_c[1] = 1'b1; sw_s[1] = 1'b0;
        for (int i = 2; i < NSW; i++) begin
            sw_a[i] = $urandom; sw_b[i] = $urandom;
            sw_c[i] = 1'($urandom_range(0, 1)); sw_s[i] = 1'($urandom_range(0, 1));
        end
        for (int k = 0; k < NSW + 2; k++) begin
            @(negedge clk);
            if (k >= 2) begin
                for (int d = 0; d < 4; d++) begin
                    want = model(wd[d], sw_a[k-2], sw_b[k-2], sw_c[k-2], sw_s[k-2]);
                    n_vec++;
                    if (ovld[d] !== 1'b1 || {oz[d], oo[d], oc[d], os[d]} !== want) begin
                        n_err++;
                        $display("FAIL sweep_w%0d_dut%0d_vec%0d: got v=%b z/o/c/sum=%h, want v=1 %h",
                                 wd[d], d, k - 2, ovld[d], {oz[d], oo[d], oc[d], os[d]}, want);
                    end
                end
                if (k == 3) begin
                    n_vec++;
                    if ({oc[0], oo[0], s8} !== {1'b1, 1'b0, 8'hFF}) begin
                        n_err++;
                        $display("FAIL w8_ff_ff_cin: got c/o/sum=%b%b %h, want 10 ff", oc[0], oo[0], s8);
                    end
                end
            end
            if (k < NSW) begin
                in_valid = 1'b1;
                a_drv = sw_a[k]; b_drv = sw_b[k]; cin = sw_c[k]; sub = sw_s[k];
            end else begin
                in_valid = 1'b0;
            end
        end
    endtask

    initial begin
        test_reset();
        test_carry_chain();
        test_overflow_add();
        test_subtract();
        test_back_to_back();
        test_reset_mid_flight();
        test_param_sweep();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
